// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/forward/flush control for the 5-stage MIPS pipe; define HAZARD_STALL_CNT_EN to enable the stall_cnt counter
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A_rsD,
    input  logic [4:0]  A_rtD,
    input  logic [1:0]  TuseRsD,
    input  logic [1:0]  TuseRtD,
    input  logic [4:0]  AwriteE,
    input  logic [4:0]  AwriteM,
    input  logic [4:0]  AwriteW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic [4:0]  A_rsE,
    input  logic [4:0]  A_rtE,
    input  logic [1:0]  TnewE,
    input  logic [1:0]  TnewM,
    input  logic        md_useD,
    input  logic        startE,
    input  logic        md_divE,
    input  logic        eretD,
    input  logic        mtcoE,
    input  logic        mtcoM,
    input  logic [4:0]  rdE,
    input  logic [4:0]  rdM,
    input  logic        exc_req,
    output logic        stallF,
    output logic        stallD,
    output logic        clrE,
    output logic        CLR,
    output logic [1:0]  fwd_rsD,
    output logic [1:0]  fwd_rtD,
    output logic [1:0]  fwd_rsE,
    output logic [1:0]  fwd_rtE,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);
    localparam logic [CNT_W-1:0] MULT_L = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_L  = CNT_W'(DIV_CYC);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic stall_dat, stall_md, stall_eret, stall;
    function automatic logic match(input logic we, input logic [4:0] aw, input logic [4:0] r);
        return r != 5'd0 && we && aw == r;
    endfunction
    always_comb begin
        stall_dat  = (match(RegWriteE, AwriteE, A_rsD) && TuseRsD < TnewE) ||
                     (match(RegWriteM, AwriteM, A_rsD) && TuseRsD < TnewM) ||
                     (match(RegWriteE, AwriteE, A_rtD) && TuseRtD < TnewE) ||
                     (match(RegWriteM, AwriteM, A_rtD) && TuseRtD < TnewM);
        md_busy    = startE || cnt_q != '0;
        stall_md   = md_useD && md_busy;
        stall_eret = eretD && ((mtcoE && rdE == 5'd14) || (mtcoM && rdM == 5'd14));
        stall      = stall_dat || stall_md || stall_eret;
        stallF     = stall && !exc_req;
        stallD     = stallF;
        clrE       = stallF;
        CLR        = exc_req;
        fwd_rsD    = (match(RegWriteE, AwriteE, A_rsD) && TnewE == 2'd0) ? 2'd1 :
                     (match(RegWriteM, AwriteM, A_rsD) && TnewM == 2'd0) ? 2'd2 : 2'd0;
        fwd_rtD    = (match(RegWriteE, AwriteE, A_rtD) && TnewE == 2'd0) ? 2'd1 :
                     (match(RegWriteM, AwriteM, A_rtD) && TnewM == 2'd0) ? 2'd2 : 2'd0;
        fwd_rsE    = (match(RegWriteM, AwriteM, A_rsE) && TnewM == 2'd0) ? 2'd1 :
                     match(RegWriteW, AwriteW, A_rsE) ? 2'd2 : 2'd0;
        fwd_rtE    = (match(RegWriteM, AwriteM, A_rtE) && TnewM == 2'd0) ? 2'd1 :
                     match(RegWriteW, AwriteW, A_rtE) ? 2'd2 : 2'd0;
        cnt_d      = (startE && !exc_req) ? (md_divE ? DIV_L : MULT_L) :
                     (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk)
        cnt_q <= reset ? '0 : cnt_d;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    always_comb
        stall_cnt_d = (stallD && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    always_ff @(posedge clk)
        stall_cnt_q <= reset ? '0 : stall_cnt_d;
    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table, hand sequences and randomized run against a cycle-timestamp busy model
module tb_hazard_ctrl;
    logic        clk, reset;
    logic [4:0]  A_rsD, A_rtD, AwriteE, AwriteM, AwriteW, A_rsE, A_rtE, rdE, rdM;
    logic [1:0]  TuseRsD, TuseRtD, TnewE, TnewM;
    logic        RegWriteE, RegWriteM, RegWriteW, md_useD, startE, md_divE, eretD, mtcoE, mtcoM, exc_req;
    logic        stallF, stallD, clrE, CLR, md_busy;
    logic [1:0]  fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE;
    logic [31:0] stall_cnt;
    int n_chk = 0, n_fail = 0;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .A_rsD(A_rsD), .A_rtD(A_rtD), .TuseRsD(TuseRsD), .TuseRtD(TuseRtD),
        .AwriteE(AwriteE), .AwriteM(AwriteM), .AwriteW(AwriteW), .RegWriteE(RegWriteE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .A_rsE(A_rsE), .A_rtE(A_rtE), .TnewE(TnewE),
        .TnewM(TnewM), .md_useD(md_useD), .startE(startE), .md_divE(md_divE), .eretD(eretD),
        .mtcoE(mtcoE), .mtcoM(mtcoM), .rdE(rdE), .rdM(rdM), .exc_req(exc_req), .stallF(stallF),
        .stallD(stallD), .clrE(clrE), .CLR(CLR), .fwd_rsD(fwd_rsD), .fwd_rtD(fwd_rtD),
        .fwd_rsE(fwd_rsE), .fwd_rtE(fwd_rtE), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] awE, awM, awW;
        logic       weE, weM, weW;
        logic [1:0] tnE, tnM;
        logic [4:0] rsD, rtD;
        logic [1:0] turs, turt;
        logic [4:0] rsE, rtE;
        logic       exc;
        logic       x_stall, x_clr;
        logic [1:0] x_frsD, x_frtD, x_frsE, x_frtE;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic idle();
        A_rsD = 0; A_rtD = 0; TuseRsD = 3; TuseRtD = 3;
        AwriteE = 0; AwriteM = 0; AwriteW = 0; RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        A_rsE = 0; A_rtE = 0; TnewE = 0; TnewM = 0; md_useD = 0; startE = 0; md_divE = 0;
        eretD = 0; mtcoE = 0; mtcoM = 0; rdE = 0; rdM = 0; exc_req = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        step();
        reset = 0;
        #1;
    endtask

    function automatic bit m(bit we, logic [4:0] aw, logic [4:0] r);
        return r != 0 && we && aw == r;
    endfunction

    vec_t tbl[12];
    logic [31:0] exp_sc;

    initial begin
        tbl[0]  = '{awE:31, weE:1, rsD:31, turs:0, x_frsD:1, default:0};
        tbl[1]  = '{awE:1, weE:1, tnE:2, rsD:1, turs:1, x_stall:1, default:0};
        tbl[2]  = '{awE:1, weE:1, tnE:2, rsD:1, turs:1, exc:1, x_clr:1, default:0};
        tbl[3]  = '{weE:1, tnE:2, default:0};
        tbl[4]  = '{awE:2, weE:1, awM:2, weM:1, rtD:2, turt:1, x_frtD:1, default:0};
        tbl[5]  = '{awM:3, weM:1, rsD:3, turs:1, rsE:3, x_frsD:2, x_frsE:1, default:0};
        tbl[6]  = '{awW:4, weW:1, rtE:4, x_frtE:2, default:0};
        tbl[7]  = '{awM:5, weM:1, awW:5, weW:1, rsE:5, x_frsE:1, default:0};
        tbl[8]  = '{awE:6, tnE:2, rsD:6, default:0};
        tbl[9]  = '{awM:7, weM:1, tnM:1, rtD:7, turt:1, default:0};
        tbl[10] = '{awM:7, weM:1, tnM:1, rtD:7, turt:0, x_stall:1, default:0};
        tbl[11] = '{awM:8, weM:1, tnM:1, awW:8, weW:1, rsE:8, turs:3, turt:3, x_frsE:2, default:0};

        do_reset();
        chk("rst_stallD", stallD, 0);
        chk("rst_CLR", CLR, 0);
        chk("rst_busy", md_busy, 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        for (int i = 0; i < 3; i++) begin
            eretD = 1; mtcoM = 1; rdM = 14;
            #1;
            chk("eret_stall", stallD, 1);
            step();
        end
        idle();
        #1;
`ifdef HAZARD_STALL_CNT_EN
        exp_sc = 3;
`else
        exp_sc = 0;
`endif
        chk("stall_cnt_3", stall_cnt, exp_sc);

        for (int i = 0; i < 12; i++) begin
            idle();
            AwriteE = tbl[i].awE; AwriteM = tbl[i].awM; AwriteW = tbl[i].awW;
            RegWriteE = tbl[i].weE; RegWriteM = tbl[i].weM; RegWriteW = tbl[i].weW;
            TnewE = tbl[i].tnE; TnewM = tbl[i].tnM; A_rsD = tbl[i].rsD; A_rtD = tbl[i].rtD;
            TuseRsD = tbl[i].turs; TuseRtD = tbl[i].turt; A_rsE = tbl[i].rsE; A_rtE = tbl[i].rtE;
            exc_req = tbl[i].exc;
            #1;
            chk($sformatf("v%0d_stallF", i), stallF, tbl[i].x_stall);
            chk($sformatf("v%0d_stallD", i), stallD, tbl[i].x_stall);
            chk($sformatf("v%0d_clrE", i), clrE, tbl[i].x_stall);
            chk($sformatf("v%0d_CLR", i), CLR, tbl[i].x_clr);
            chk($sformatf("v%0d_frsD", i), fwd_rsD, tbl[i].x_frsD);
            chk($sformatf("v%0d_frtD", i), fwd_rtD, tbl[i].x_frtD);
            chk($sformatf("v%0d_frsE", i), fwd_rsE, tbl[i].x_frsE);
            chk($sformatf("v%0d_frtE", i), fwd_rtE, tbl[i].x_frtE);
            step();
        end

        idle();
        AwriteE = 1; RegWriteE = 1; TnewE = 2; A_rsD = 1; TuseRsD = 1;
        #1;
        chk("lw_stall", stallD, 1);
        step();
        idle();
        AwriteM = 1; RegWriteM = 1; TnewM = 0; A_rsD = 1; TuseRsD = 1;
        #1;
        chk("lw_nostall", stallD, 0);
        chk("lw_fwdM", fwd_rsD, 2);
        step();

        idle();
        startE = 1; md_divE = 1; md_useD = 1;
        #1;
        chk("div_stall0", stallD, 1);
        step();
        startE = 0; md_divE = 0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            chk($sformatf("div_stall%0d", i), stallD, 1);
            chk($sformatf("div_busy%0d", i), md_busy, 1);
            step();
        end
        chk("div_done_stall", stallD, 0);
        chk("div_done_busy", md_busy, 0);
        step();

        idle();
        startE = 1; md_useD = 1; exc_req = 1;
        #1;
        chk("mexc_CLR", CLR, 1);
        chk("mexc_stall", stallD, 0);
        step();
        idle();
        #1;
        chk("mexc_busy", md_busy, 0);

        eretD = 1; mtcoM = 1; rdM = 14;
        #1;
        chk("mtc0_stall", stallD, 1);
        step();
        mtcoM = 0;
        #1;
        chk("mtc0_gone", stallD, 0);
        step();

        begin
            int cyc, busy_until;
            bit e_stall, e_busy, s_go, s_div, s_exc;
            logic [31:0] sc;
            do_reset();
            cyc = 0; busy_until = -1; sc = 0;
            for (int n = 0; n < 1500; n++) begin
                A_rsD = 5'($urandom_range(3)); A_rtD = 5'($urandom_range(3));
                A_rsE = 5'($urandom_range(3)); A_rtE = 5'($urandom_range(3));
                AwriteE = 5'($urandom_range(3)); AwriteM = 5'($urandom_range(3)); AwriteW = 5'($urandom_range(3));
                RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
                TuseRsD = 2'($urandom); TuseRtD = 2'($urandom); TnewE = 2'($urandom); TnewM = 2'($urandom);
                md_useD = 1'($urandom); md_divE = 1'($urandom);
                startE = (cyc > busy_until) && $urandom_range(3) == 0;
                eretD = 1'($urandom); mtcoE = 1'($urandom); mtcoM = 1'($urandom);
                rdE = 5'($urandom_range(15, 13)); rdM = 5'($urandom_range(15, 13));
                exc_req = $urandom_range(7) == 0;
                #1;
                e_busy  = startE || cyc <= busy_until;
                e_stall = !exc_req && (
                    (m(RegWriteE, AwriteE, A_rsD) && TuseRsD < TnewE) || (m(RegWriteM, AwriteM, A_rsD) && TuseRsD < TnewM) ||
                    (m(RegWriteE, AwriteE, A_rtD) && TuseRtD < TnewE) || (m(RegWriteM, AwriteM, A_rtD) && TuseRtD < TnewM) ||
                    (md_useD && e_busy) || (eretD && ((mtcoE && rdE == 14) || (mtcoM && rdM == 14))));
                chk("r_busy", md_busy, e_busy);
                chk("r_stallF", stallF, e_stall);
                chk("r_stallD", stallD, e_stall);
                chk("r_clrE", clrE, e_stall);
                chk("r_CLR", CLR, exc_req);
                chk("r_frsD", fwd_rsD, (m(RegWriteE, AwriteE, A_rsD) && TnewE == 0) ? 1 : (m(RegWriteM, AwriteM, A_rsD) && TnewM == 0) ? 2 : 0);
                chk("r_frtD", fwd_rtD, (m(RegWriteE, AwriteE, A_rtD) && TnewE == 0) ? 1 : (m(RegWriteM, AwriteM, A_rtD) && TnewM == 0) ? 2 : 0);
                chk("r_frsE", fwd_rsE, (m(RegWriteM, AwriteM, A_rsE) && TnewM == 0) ? 1 : m(RegWriteW, AwriteW, A_rsE) ? 2 : 0);
                chk("r_frtE", fwd_rtE, (m(RegWriteM, AwriteM, A_rtE) && TnewM == 0) ? 1 : m(RegWriteW, AwriteW, A_rtE) ? 2 : 0);
`ifdef HAZARD_STALL_CNT_EN
                chk("r_stall_cnt", stall_cnt, sc);
`else
                chk("r_stall_cnt", stall_cnt, 0);
`endif
                s_go = startE; s_div = md_divE; s_exc = exc_req;
                @(posedge clk);
                if (s_go && !s_exc) busy_until = cyc + (s_div ? 10 : 5);
                if (e_stall) sc = sc + 1;
                cyc++;
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
